// File: rtl/mul_rs.sv
// Multiply reservation station: age-ordered oldest-ready select with CDB wakeup.
// Define MUL_RS_SAME_CYCLE_WAKEUP_EN to let a CDB hit make an entry issue in the same cycle.
module mul_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         dispatch_valid_i,
  output logic                         dispatch_ready_o,
  input  logic [31:0]                  dispatch_pc_i,
  input  logic [31:0]                  dispatch_inst_i,
  input  logic [TAG_W-1:0]             dispatch_rd_tag_i,
  input  logic                         dispatch_rs1_ready_i,
  input  logic                         dispatch_rs2_ready_i,
  input  logic [31:0]                  dispatch_rs1_value_i,
  input  logic [31:0]                  dispatch_rs2_value_i,
  input  logic [TAG_W-1:0]             dispatch_rs1_tag_i,
  input  logic [TAG_W-1:0]             dispatch_rs2_tag_i,
  input  logic                         cdb_valid_i,
  input  logic [TAG_W-1:0]             cdb_tag_i,
  input  logic [31:0]                  cdb_value_i,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [31:0]                  issue_pc_o,
  output logic [31:0]                  issue_inst_o,
  output logic [31:0]                  issue_rs1_value_o,
  output logic [31:0]                  issue_rs2_value_o,
  output logic [TAG_W-1:0]             issue_rd_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             ready;
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
  } src_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd_tag;
    src_t             rs1;
    src_t             rs2;
  } entry_t;

  logic   [DEPTH-1:0]            valid_q, valid_d;
  // older_q[i][j] set means entry j was dispatched before entry i.
  logic   [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  entry_t [DEPTH-1:0]            entry_q, entry_d;

  entry_t [DEPTH-1:0] view;
  logic   [DEPTH-1:0] eligible;
  logic   [IDX_W-1:0] sel_idx;
  logic   [IDX_W-1:0] alloc_idx;
  logic   [OCC_W-1:0] occupancy;
  logic               dispatch_fire;
  logic               issue_fire;
  entry_t             new_entry;

  function automatic src_t capture(input src_t s, input logic cv,
                                   input logic [TAG_W-1:0] ct, input logic [31:0] cval);
    capture = s;
    if (!s.ready && cv && (s.tag == ct)) begin
      capture.ready = 1'b1;
      capture.value = cval;
    end
  endfunction

  // Occupancy and the lowest free slot come from registered valid bits only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    occupancy = '0;
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign dispatch_ready_o = (occupancy < OCC_W'(DEPTH));
  assign occupancy_o      = occupancy;

  // Select view: registered operands, or CDB-forwarded operands in same-cycle mode.
  always_comb begin
    view = entry_q;
`ifdef MUL_RS_SAME_CYCLE_WAKEUP_EN
    for (int i = 0; i < DEPTH; i++) begin
      view[i].rs1 = capture(entry_q[i].rs1, cdb_valid_i, cdb_tag_i, cdb_value_i);
      view[i].rs2 = capture(entry_q[i].rs2, cdb_valid_i, cdb_tag_i, cdb_value_i);
    end
`endif
    for (int i = 0; i < DEPTH; i++)
      eligible[i] = valid_q[i] && view[i].rs1.ready && view[i].rs2.ready;
  end

  // Oldest eligible entry: eligible with no eligible entry older than it.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (eligible[i] && !(|(older_q[i] & eligible))) sel_idx = IDX_W'(i);
  end

  assign issue_valid_o = (|eligible) && !flush_i;
  assign issue_fire    = issue_valid_o && issue_ready_i;
  assign dispatch_fire = dispatch_valid_i && dispatch_ready_o && !flush_i;

  always_comb begin
    issue_pc_o        = '0;
    issue_inst_o      = '0;
    issue_rs1_value_o = '0;
    issue_rs2_value_o = '0;
    issue_rd_tag_o    = '0;
    if (issue_valid_o) begin
      issue_pc_o        = view[sel_idx].pc;
      issue_inst_o      = view[sel_idx].inst;
      issue_rs1_value_o = view[sel_idx].rs1.value;
      issue_rs2_value_o = view[sel_idx].rs2.value;
      issue_rd_tag_o    = view[sel_idx].rd_tag;
    end
  end

  always_comb begin
    new_entry.pc     = dispatch_pc_i;
    new_entry.inst   = dispatch_inst_i;
    new_entry.rd_tag = dispatch_rd_tag_i;
    new_entry.rs1    = capture('{dispatch_rs1_ready_i, dispatch_rs1_tag_i, dispatch_rs1_value_i},
                               cdb_valid_i, cdb_tag_i, cdb_value_i);
    new_entry.rs2    = capture('{dispatch_rs2_ready_i, dispatch_rs2_tag_i, dispatch_rs2_value_i},
                               cdb_valid_i, cdb_tag_i, cdb_value_i);
  end

  always_comb begin
    valid_d = valid_q;
    older_d = older_q;
    entry_d = entry_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i].rs1 = capture(entry_q[i].rs1, cdb_valid_i, cdb_tag_i, cdb_value_i);
      entry_d[i].rs2 = capture(entry_q[i].rs2, cdb_valid_i, cdb_tag_i, cdb_value_i);
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (dispatch_fire) begin
      valid_d[alloc_idx] = 1'b1;
      entry_d[alloc_idx] = new_entry;
      // Clear stale "older" claims about the reused slot, then make it youngest.
      for (int i = 0; i < DEPTH; i++) older_d[i][alloc_idx] = 1'b0;
      older_d[alloc_idx] = valid_q;
    end
    if (flush_i) valid_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      older_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
    end
  end

  // NOTE: the payload array is not reset; it is only observed through valid bits and gated outputs.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

endmodule

// File: doc/mul_rs.md
# mul_rs

Reservation station for the multiply functional unit. Buffers dispatched multiply instructions until both source operands are known, captures missing operands from the common data bus (CDB), and issues the oldest ready entry to the multiplier. `issue_valid_o` drives the multiplier's request input directly. The instruction, pc and operand values feed the multiplier's instruction and rs1/rs2 inputs.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- TAG_W, 6, physical/ROB tag width
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all entries (mispredict/exception)
- dispatch_valid_i  in  1  dispatch request
- dispatch_ready_o  out  1  free entry available
- dispatch_pc_i  in  32  instruction pc
- dispatch_inst_i  in  32  raw instruction (funct3 in [14:12])
- dispatch_rd_tag_i  in  TAG_W  destination tag
- dispatch_rs1_ready_i / dispatch_rs2_ready_i  in  1  operand value valid
- dispatch_rs1_value_i / dispatch_rs2_value_i  in  32  operand value
- dispatch_rs1_tag_i / dispatch_rs2_tag_i  in  TAG_W  producer tag when not ready
- cdb_valid_i  in  1  CDB broadcast
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_value_i  in  32  broadcast value
- issue_valid_o  out  1  entry presented to multiplier
- issue_ready_i  in  1  multiplier accepts this cycle
- issue_pc_o, issue_inst_o, issue_rs1_value_o, issue_rs2_value_o  out  32  issued payload
- issue_rd_tag_o  out  TAG_W  issued destination tag
- occupancy_o  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Each entry holds: valid, pc, inst, rd_tag, and per source {ready, tag, value}. An age matrix (DEPTH×DEPTH) records dispatch order.
- Dispatch: fires when dispatch_valid_i && dispatch_ready_o. It writes the lowest-index free entry and marks that entry younger than all valid entries.
- Dispatch-time capture: if a source is not ready and cdb_valid_i matches its tag in the same cycle, the source is stored as ready with cdb_value_i.
- Wakeup: every valid entry compares each non-ready source tag with cdb_tag_i when cdb_valid_i is high. On a match it stores the value and sets ready. Both sources may wake on one broadcast.
- Select: an entry is eligible when it is valid and both sources are ready. issue_valid_o = any eligible entry. The payload comes from the oldest eligible entry.
- When issue_valid_o is low, payload outputs are driven to 0.
- Issue handshake: on issue_valid_o && issue_ready_i, the selected entry is cleared at the clock edge. The payload must stay stable while issue_valid_o is high and issue_ready_i is low, unless an older entry becomes eligible.
- dispatch_ready_o = occupancy_o < DEPTH, computed from registered state. A slot freed by issue becomes usable for dispatch in the following cycle.
- Flush: clears all valid bits at the next edge. A dispatch in the same cycle is dropped. issue_valid_o is forced to 0 while flush_i is high.
- Dispatch, wakeup and issue may all occur in one cycle without conflict. occupancy_o changes by +1, -1, or 0.
- The block does not decode funct3. The dispatcher sends only funct3[2]==0 operations.

## Timing
- Reset (async): all entries invalid, age matrix cleared. issue_valid_o=0, payload outputs=0, dispatch_ready_o=1, occupancy_o=0.
- Dispatch with both operands ready at edge N: issue_valid_o high in cycle N+1 (one-cycle minimum latency).
- CDB broadcast in cycle N: the entry is eligible in cycle N+1 by default (see Configuration).
- Deassertion of reset_i is synchronous to clk_i externally; no internal synchronizer.

## Configuration
- MUL_RS_SAME_CYCLE_WAKEUP_EN defined: eligibility also counts a source as ready when the CDB matches it in the current cycle. The issue value muxes cdb_value_i combinationally, so wakeup-to-issue latency is 0 cycles. This adds a CDB-to-issue combinational path.
- MUL_RS_SAME_CYCLE_WAKEUP_EN undefined: eligibility uses registered ready bits only, so wakeup-to-issue latency is 1 cycle.

## Test plan
- Reset then dispatch pc=0x100, rs1=7, rs2=6, both ready, issue_ready_i=1 -> issue_valid_o high next cycle with rs1/rs2=7/6. occupancy_o goes 0→1→0.
- Dispatch rs1 waiting on tag 5, then CDB tag=5 value=0xFFFFFFFF -> issue one cycle after the broadcast with issue_rs1_value_o=0xFFFFFFFF (0 cycles with the macro).
- Fill DEPTH=4 entries in order A,B,C,D with all ready and issue_ready_i=0 -> dispatch_ready_o=0, extra dispatch ignored. Release issue_ready_i -> issue order A,B,C,D.
- Dispatch A waiting on tag 3 and B ready, then wake A -> B issues first. A issues only after wakeup, and ahead of any later-dispatched ready entry.
- Dispatch with rs2 tag=9 while CDB broadcasts tag=9 value=0x1234 in the same cycle -> entry captures 0x1234 and issues next cycle.
- 3 valid entries, flush_i with a simultaneous dispatch -> occupancy_o=0 and issue_valid_o=0 the next cycle. Assert reset_i mid-operation -> all outputs at reset values immediately.
